// File: rtl/wwm_input_conditioner.sv
// wwm_input_conditioner: synchronizes/debounces Start and Fire buttons and registers velocity switches with freeze.
// Optional auto-repeat of held buttons is enabled by defining WWM_AUTOREPEAT_EN.
module wwm_debounce_fsm #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic pulse,
    output logic level
);
`ifdef WWM_AUTOREPEAT_EN
    localparam bit AR_EN = 1'b1;
`else
    localparam bit AR_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, ARM, PULSE, HELD, REL} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (sync_in) begin
                state_d = ARM;
                cnt_d   = '0;
            end
            ARM: if (!sync_in) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
                state_d = PULSE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            PULSE: begin
                state_d = HELD;
                cnt_d   = '0;
            end
            // A repeat re-enters PULSE so every pulse is followed by a fresh HELD entry
            HELD: if (!sync_in) begin
                state_d = REL;
                cnt_d   = '0;
            end else if (AR_EN && cnt_q == RP_LAST) begin
                state_d = PULSE;
                cnt_d   = '0;
            end else if (AR_EN) cnt_d = cnt_q + 1'b1;
            REL: if (sync_in) begin
                state_d = HELD;
                cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign pulse = (state_q == PULSE);
    assign level = (state_q == PULSE) || (state_q == HELD) || (state_q == REL);
endmodule

module wwm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       BtnU_raw,
    input  logic       BtnR_raw,
    input  logic [7:0] Sw,
    input  logic       freeze,
    output logic       Start_pulse,
    output logic       Fire_pulse,
    output logic       Start_level,
    output logic       Fire_level,
    output logic [3:0] vX,
    output logic [3:0] vY
);
    logic [9:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0] vx_q, vx_d, vy_q, vy_d;
    always_comb begin
        sync1_d = {BtnU_raw, BtnR_raw, Sw};
        sync2_d = sync1_q;
        vx_d    = freeze ? vx_q : sync2_q[7:4];
        vy_d    = freeze ? vy_q : sync2_q[3:0];
    end
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
        end
    end
    wwm_debounce_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W(CNT_W)
    ) u_start (
        .clk(clk),
        .rst(Reset),
        .sync_in(sync2_q[9]),
        .pulse(Start_pulse),
        .level(Start_level)
    );
    wwm_debounce_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W(CNT_W)
    ) u_fire (
        .clk(clk),
        .rst(Reset),
        .sync_in(sync2_q[8]),
        .pulse(Fire_pulse),
        .level(Fire_level)
    );
    assign vX = vx_q;
    assign vY = vy_q;
endmodule
